// File: rtl/game_seq_ctl_pkg.sv
// Shared types and constants for the game sequencer slice.
// The optional score counter is enabled by defining GAME_SCORE_EN.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PLAY       = 3'd1,
    HIT        = 3'd2,
    WAVE_PAUSE = 3'd3,
    GAME_OVER  = 3'd4
  } game_state_t;

  localparam int LIVES_INIT_DEF       = 3;
  localparam int HIT_FREEZE_TICKS_DEF = 120;
  localparam int WAVE_PAUSE_TICKS_DEF = 90;
  localparam int MAX_WAVE_DEF         = 15;

  localparam int LIVES_W      = 2;
  localparam int WAVE_W       = 4;
  localparam int SCORE_DIGITS = 4;
  localparam int SCORE_W      = 4 * SCORE_DIGITS;

  // The shared freeze/pause timer only ever holds values up to N-1.
  function automatic int tmr_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/game_seq_ctl_if.sv
// Frame strobe, player/enemy events and session status between the
// game sequencer (slave) and the rest of the game (master).
interface game_seq_ctl_if;
  import game_pkg::*;

  logic                tick;
  logic                start_btn;
  logic                player_hit;
  logic                wave_cleared;
  logic                enemy_killed;
  game_state_t         state;
  logic                play_en;
  logic                field_rst;
  logic [LIVES_W-1:0]  lives;
  logic [WAVE_W-1:0]   wave;
  logic [SCORE_W-1:0]  score;

  modport master (
    output tick, start_btn, player_hit, wave_cleared, enemy_killed,
    input  state, play_en, field_rst, lives, wave, score
  );

  modport slave (
    input  tick, start_btn, player_hit, wave_cleared, enemy_killed,
    output state, play_en, field_rst, lives, wave, score
  );

endinterface

// File: rtl/game_seq_ctl_bcd_score_cnt.sv
// Saturating multi-digit BCD kill counter; only built when GAME_SCORE_EN
// is defined.
`ifdef GAME_SCORE_EN
module bcd_score_cnt #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                inc,
  output logic [4*DIGITS-1:0] score
);

  logic [4*DIGITS-1:0] score_q, score_d;
  logic                all_nine;
  logic                carry;

  always_comb begin
    score_d  = score_q;
    all_nine = 1'b1;
    carry    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (score_q[4*i +: 4] != 4'd9) all_nine = 1'b0;
    end
    if (clr) begin
      score_d = '0;
    end else if (inc && !all_nine) begin
      // Ripple the +1 upward until a digit absorbs it without wrapping.
      for (int i = 0; i < DIGITS; i++) begin
        if (carry) begin
          if (score_q[4*i +: 4] == 4'd9) begin
            score_d[4*i +: 4] = 4'd0;
          end else begin
            score_d[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
            carry             = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) score_q <= '0;
    else     score_q <= score_d;
  end

  assign score = score_q;

endmodule
`endif

// File: rtl/game_seq_ctl.sv
// Session state machine: attract, play, respawn freeze, wave pause, game over.
// Define GAME_SCORE_EN to include the BCD score counter; otherwise score is 0.
module game_seq_ctl
  import game_pkg::*;
#(
  parameter int LIVES_INIT       = LIVES_INIT_DEF,
  parameter int HIT_FREEZE_TICKS = HIT_FREEZE_TICKS_DEF,
  parameter int WAVE_PAUSE_TICKS = WAVE_PAUSE_TICKS_DEF,
  parameter int MAX_WAVE         = MAX_WAVE_DEF
) (
  input logic           clk,
  input logic           rst,
  game_seq_ctl_if.slave gi
);

  localparam int                 TMR_W      = tmr_width(HIT_FREEZE_TICKS, WAVE_PAUSE_TICKS);
  localparam logic [TMR_W-1:0]   HIT_LAST   = TMR_W'(HIT_FREEZE_TICKS - 1);
  localparam logic [TMR_W-1:0]   WAVE_LAST  = TMR_W'(WAVE_PAUSE_TICKS - 1);
  localparam logic [LIVES_W-1:0] LIVES_LOAD = LIVES_W'(LIVES_INIT);
  localparam logic [LIVES_W-1:0] LIVES_ONE  = LIVES_W'(1);
  localparam logic [WAVE_W-1:0]  WAVE_MAX   = WAVE_W'(MAX_WAVE);

  game_state_t        state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [WAVE_W-1:0]  wave_q, wave_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               play_en_q, field_rst_q;
  logic               play_en_d, field_rst_d;
  logic               start_btn_q;
  logic               start_rise;
  logic               score_clr, score_inc;
  logic [SCORE_W-1:0] score_q;

  // A held button yields a single rise because start_btn_q follows it.
  assign start_rise = gi.start_btn & ~start_btn_q;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    wave_d    = wave_q;
    tmr_d     = tmr_q;
    score_clr = 1'b0;
    score_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_rise) begin
          state_d   = PLAY;
          lives_d   = LIVES_LOAD;
          wave_d    = '0;
          score_clr = 1'b1;
        end
      end
      PLAY: begin
        tmr_d     = '0;
        score_inc = gi.enemy_killed;
        if (gi.player_hit) begin
          if (lives_q > LIVES_ONE) begin
            state_d = HIT;
            lives_d = lives_q - LIVES_ONE;
          end else begin
            state_d = GAME_OVER;
            lives_d = '0;
          end
        end else if (gi.wave_cleared) begin
          state_d = WAVE_PAUSE;
          if (wave_q != WAVE_MAX) wave_d = wave_q + WAVE_W'(1);
        end
      end
      HIT: begin
        if (gi.tick) begin
          if (tmr_q == HIT_LAST) state_d = PLAY;
          else                   tmr_d   = tmr_q + TMR_W'(1);
        end
      end
      WAVE_PAUSE: begin
        if (gi.tick) begin
          if (tmr_q == WAVE_LAST) state_d = PLAY;
          else                    tmr_d   = tmr_q + TMR_W'(1);
        end
      end
      GAME_OVER: begin
        if (start_rise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    play_en_d   = (state_d == PLAY);
    field_rst_d = (state_d == PLAY) && (state_q != PLAY);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lives_q     <= '0;
      wave_q      <= '0;
      tmr_q       <= '0;
      play_en_q   <= 1'b0;
      field_rst_q <= 1'b0;
      start_btn_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      wave_q      <= wave_d;
      tmr_q       <= tmr_d;
      play_en_q   <= play_en_d;
      field_rst_q <= field_rst_d;
      start_btn_q <= gi.start_btn;
    end
  end

`ifdef GAME_SCORE_EN
  bcd_score_cnt #(
    .DIGITS (SCORE_DIGITS)
  ) u_score (
    .clk   (clk),
    .rst   (rst),
    .clr   (score_clr),
    .inc   (score_inc),
    .score (score_q)
  );
`else
  logic unused_score;
  assign unused_score = ^{score_clr, score_inc};
  assign score_q      = '0;
`endif

  assign gi.state     = state_q;
  assign gi.play_en   = play_en_q;
  assign gi.field_rst = field_rst_q;
  assign gi.lives     = lives_q;
  assign gi.wave      = wave_q;
  assign gi.score     = score_q;

endmodule

// File: tb/tb_game_seq_ctl.sv
// Directed bench for game_seq_ctl: start, respawn, game over, wave
// saturation, score (when GAME_SCORE_EN is defined) and async reset.
module tb_game_seq_ctl;
  import game_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;

  game_seq_ctl_if gi ();

  game_seq_ctl #(
    .LIVES_INIT       (3),
    .HIT_FREEZE_TICKS (120),
    .WAVE_PAUSE_TICKS (2),
    .MAX_WAVE         (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .gi  (gi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive n ticks one every other cycle, then check the exit on the last one.
  task automatic respawn(input int n, input string tag);
    repeat (n - 1) begin
      gi.tick = 1'b1; cyc(); gi.tick = 1'b0; cyc();
    end
    check({tag, "_still_hit"}, 32'(gi.state), 32'(HIT));
    check({tag, "_play_en_low"}, 32'(gi.play_en), 32'd0);
    gi.tick = 1'b1; cyc(); gi.tick = 1'b0;
    check({tag, "_back_play"}, 32'(gi.state), 32'(PLAY));
    check({tag, "_field_rst"}, 32'(gi.field_rst), 32'd1);
    check({tag, "_play_en"}, 32'(gi.play_en), 32'd1);
    cyc();
    check({tag, "_field_rst_done"}, 32'(gi.field_rst), 32'd0);
  endtask

  initial begin
    int extra;
    gi.tick = 1'b0; gi.start_btn = 1'b0; gi.player_hit = 1'b0;
    gi.wave_cleared = 1'b0; gi.enemy_killed = 1'b0;

    // Reset values
    cyc(2);
    check("rst_state", 32'(gi.state), 32'(IDLE));
    check("rst_play_en", 32'(gi.play_en), 32'd0);
    check("rst_field_rst", 32'(gi.field_rst), 32'd0);
    check("rst_lives", 32'(gi.lives), 32'd0);
    check("rst_wave", 32'(gi.wave), 32'd0);
    check("rst_score", 32'(gi.score), 32'd0);
    rst = 1'b0;
    cyc();
    check("idle_hold", 32'(gi.state), 32'(IDLE));

    // Start rise, then hold the button for 50 cycles
    gi.start_btn = 1'b1; cyc();
    check("start_state", 32'(gi.state), 32'(PLAY));
    check("start_field_rst", 32'(gi.field_rst), 32'd1);
    check("start_lives", 32'(gi.lives), 32'd3);
    check("start_play_en", 32'(gi.play_en), 32'd1);
    cyc();
    check("start_field_rst_1cyc", 32'(gi.field_rst), 32'd0);
    extra = 0;
    for (int i = 0; i < 48; i++) begin
      cyc();
      if (gi.field_rst) extra++;
    end
    check("held_btn_no_restart", 32'(extra), 32'd0);
    check("held_btn_state", 32'(gi.state), 32'(PLAY));
    gi.start_btn = 1'b0; cyc();

    // Hit 1: lives 3 -> 2, 120 ticks of freeze
    gi.player_hit = 1'b1; cyc(); gi.player_hit = 1'b0;
    check("hit1_state", 32'(gi.state), 32'(HIT));
    check("hit1_lives", 32'(gi.lives), 32'd2);
    check("hit1_play_en", 32'(gi.play_en), 32'd0);
    respawn(120, "hit1");

    // Hit 2 with a tick in the causing cycle: that tick must not count
    gi.player_hit = 1'b1; gi.tick = 1'b1; cyc();
    gi.player_hit = 1'b0; gi.tick = 1'b0;
    check("hit2_lives", 32'(gi.lives), 32'd1);
    respawn(120, "hit2");

    // Hit 3: last life -> GAME_OVER, no field reset
    gi.player_hit = 1'b1; cyc(); gi.player_hit = 1'b0;
    check("hit3_state", 32'(gi.state), 32'(GAME_OVER));
    check("hit3_lives", 32'(gi.lives), 32'd0);
    check("hit3_field_rst", 32'(gi.field_rst), 32'd0);
    check("hit3_play_en", 32'(gi.play_en), 32'd0);
    gi.player_hit = 1'b1; gi.wave_cleared = 1'b1; gi.tick = 1'b1; cyc();
    gi.player_hit = 1'b0; gi.wave_cleared = 1'b0; gi.tick = 1'b0; cyc();
    check("over_ignore_state", 32'(gi.state), 32'(GAME_OVER));
    check("over_ignore_wave", 32'(gi.wave), 32'd0);
    gi.start_btn = 1'b1; cyc();
    check("over_to_idle", 32'(gi.state), 32'(IDLE));
    check("over_to_idle_field_rst", 32'(gi.field_rst), 32'd0);
    check("over_lives_hold", 32'(gi.lives), 32'd0);
    gi.start_btn = 1'b0; cyc();

    // New game; hit and wave clear together -> hit wins
    gi.start_btn = 1'b1; cyc(); gi.start_btn = 1'b0;
    check("game2_state", 32'(gi.state), 32'(PLAY));
    check("game2_lives", 32'(gi.lives), 32'd3);
    cyc();
    gi.player_hit = 1'b1; gi.wave_cleared = 1'b1; cyc();
    gi.player_hit = 1'b0; gi.wave_cleared = 1'b0;
    check("both_state", 32'(gi.state), 32'(HIT));
    check("both_lives", 32'(gi.lives), 32'd2);
    check("both_wave", 32'(gi.wave), 32'd0);
    respawn(120, "both");

    // 16 wave clears with a 2-tick pause -> wave saturates at 15
    extra = 0;
    for (int i = 1; i <= 16; i++) begin
      gi.wave_cleared = 1'b1; cyc(); gi.wave_cleared = 1'b0;
      check("wave_pause_state", 32'(gi.state), 32'(WAVE_PAUSE));
      check("wave_value", 32'(gi.wave), 32'((i > 15) ? 15 : i));
      gi.tick = 1'b1; cyc(); gi.tick = 1'b0;
      check("wave_pause_tick1", 32'(gi.state), 32'(WAVE_PAUSE));
      gi.tick = 1'b1; cyc(); gi.tick = 1'b0;
      if (gi.field_rst) extra++;
      check("wave_resume", 32'(gi.state), 32'(PLAY));
      cyc();
    end
    check("wave_field_rst_count", 32'(extra), 32'd16);
    check("wave_saturated", 32'(gi.wave), 32'd15);

`ifdef GAME_SCORE_EN
    gi.enemy_killed = 1'b1; cyc(99); gi.enemy_killed = 1'b0;
    check("score_99", 32'(gi.score), 32'h0099);
    gi.enemy_killed = 1'b1; cyc(); gi.enemy_killed = 1'b0;
    check("score_100", 32'(gi.score), 32'h0100);
    gi.enemy_killed = 1'b1; gi.wave_cleared = 1'b1; cyc();
    gi.enemy_killed = 1'b0; gi.wave_cleared = 1'b0;
    check("score_kill_with_clear", 32'(gi.score), 32'h0101);
    check("score_clear_state", 32'(gi.state), 32'(WAVE_PAUSE));
    gi.enemy_killed = 1'b1; gi.tick = 1'b1; cyc();
    gi.enemy_killed = 1'b0; gi.tick = 1'b0;
    check("score_ignore_in_pause", 32'(gi.score), 32'h0101);
    gi.tick = 1'b1; cyc(); gi.tick = 1'b0;
    check("score_resume", 32'(gi.state), 32'(PLAY));
    gi.enemy_killed = 1'b1; cyc(10005 - 101); gi.enemy_killed = 1'b0;
    check("score_saturate", 32'(gi.score), 32'h9999);
`else
    gi.enemy_killed = 1'b1; cyc(5); gi.enemy_killed = 1'b0;
    check("score_tied_zero", 32'(gi.score), 32'h0000);
`endif

    // Asynchronous reset in the middle of HIT
    gi.player_hit = 1'b1; cyc(); gi.player_hit = 1'b0;
    check("pre_rst_state", 32'(gi.state), 32'(HIT));
    check("pre_rst_lives", 32'(gi.lives), 32'd1);
    gi.tick = 1'b1; cyc(3); gi.tick = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("arst_state", 32'(gi.state), 32'(IDLE));
    check("arst_play_en", 32'(gi.play_en), 32'd0);
    check("arst_field_rst", 32'(gi.field_rst), 32'd0);
    check("arst_lives", 32'(gi.lives), 32'd0);
    check("arst_wave", 32'(gi.wave), 32'd0);
    check("arst_score", 32'(gi.score), 32'd0);
    cyc(2);
    rst = 1'b0;
    cyc(2);
    check("post_rst_idle", 32'(gi.state), 32'(IDLE));
    check("post_rst_field_rst", 32'(gi.field_rst), 32'd0);
    gi.start_btn = 1'b1; cyc(); gi.start_btn = 1'b0;
    check("post_rst_start", 32'(gi.state), 32'(PLAY));
    check("post_rst_lives", 32'(gi.lives), 32'd3);
    check("post_rst_field_rst_pulse", 32'(gi.field_rst), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
